priority_scan_encoder: RTL and testbench
========================================

PRIORITY_SCAN_ENCODER -- requirements
Module: priority_scan_encoder

Interface
REQ-001 Parameter WIDTH, default 64, request-vector width; SHALL be a power of two, >= 2.
REQ-002 Parameter IDX_W, default $clog2(WIDTH), index width; SHALL be derived, never overridden.
REQ-003 clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 load_valid  input  1  load_vec presented.
REQ-006 load_ready  output  1  block accepts a new vector.
REQ-007 load_vec  input  WIDTH  bit i set = pending request i (e.g. implied literal i).
REQ-008 out_valid  output  1  out_idx valid.
REQ-009 out_ready  input  1  consumer accepts out_idx.
REQ-010 out_idx  output  IDX_W  index of highest set pending bit.
REQ-011 out_last  output  1  out_idx is the final pending bit.
REQ-012 pend_cnt  output  IDX_W+1  number of pending bits still held.
REQ-013 flush  input  1  abandon current vector.
REQ-014 done  output  1  one-cycle pulse at vector completion.

Function
REQ-015 SHALL hold two states: IDLE, SCAN.
REQ-016 IDLE: load_ready=1, out_valid=0; SCAN: load_ready=0, out_valid=1.
REQ-017 Load handshake (load_valid && load_ready) with nonzero load_vec SHALL register vector, set pend_cnt to popcount(load_vec), enter SCAN; out_valid SHALL rise the next cycle (latency 1).
REQ-018 Load handshake with load_vec == 0 SHALL stay IDLE and pulse done the next cycle; out_valid stays 0.
REQ-019 In SCAN, out_idx SHALL be the highest set bit of the held vector, decoded combinationally from registered state (no extra latency).
REQ-020 out_last SHALL equal (pend_cnt == 1) while out_valid; 0 otherwise.
REQ-021 Output handshake (out_valid && out_ready) SHALL clear bit out_idx and decrement pend_cnt in the same edge; throughput one index per cycle.
REQ-022 While out_valid && !out_ready, out_idx, out_last, pend_cnt SHALL hold stable.
REQ-023 Handshake with out_last=1 SHALL return to IDLE, pulse done next cycle, pend_cnt = 0.
REQ-024 Indices SHALL be emitted strictly descending; each set bit exactly once.
REQ-025 flush SHALL take priority over every other input: next cycle state IDLE, vector and pend_cnt cleared, out_valid=0, no done pulse; a simultaneous output or load handshake SHALL be discarded.
REQ-026 flush in IDLE SHALL have no visible effect beyond suppressing a same-cycle load.
REQ-027 load_valid in SCAN SHALL be ignored (no overlap); upstream holds it until load_ready.
REQ-028 WIDTH-bit vector with all bits set SHALL yield pend_cnt = WIDTH (fits IDX_W+1 bits) and WIDTH outputs, WIDTH-1 down to 0.
REQ-029 Index 0 SHALL be reachable and distinguishable from "nothing pending" only via out_valid.

Reset
REQ-030 rst_n low SHALL immediately force: state IDLE, vector 0, pend_cnt 0, out_valid 0, out_last 0, out_idx 0, done 0, load_ready 1 after release.
REQ-031 Reset mid-SCAN SHALL discard the vector with no done pulse; first load after release behaves per REQ-017.

Structure
REQ-032 State enum (IDLE, SCAN) SHALL live in shared package bcp_pkg.
REQ-033 Highest-set-bit decode SHALL be one parametrised combinational sub-module prio_enc_param (WIDTH in, IDX_W index out, any-set flag out), reusable elsewhere in the BCP datapath.
REQ-034 Popcount SHALL be computed once at load; no per-cycle popcount of the held vector.

Verification
REQ-035 WIDTH=8, load 8'b1010_0101, out_ready=1 -> out_idx 7,5,2,0 on consecutive cycles, pend_cnt 4,3,2,1, out_last on idx 0, done one cycle later.
REQ-036 WIDTH=8, load 8'h00 -> no out_valid, done pulse next cycle, load_ready stays 1.
REQ-037 WIDTH=8, load 8'hFF, out_ready toggled 1,0,0,1,... -> idx held during stalls, 8 outputs 7..0, pend_cnt never underflows.
REQ-038 WIDTH=8, load 8'b0100_1000, flush asserted with first output handshake -> IDLE next cycle, no done, subsequent load 8'h01 yields single idx 0 with out_last.
REQ-039 WIDTH=64, load all-ones, rst_n pulsed low after 10 outputs -> all outputs 0 asynchronously, no done, fresh load 64'h8000_0000_0000_0000 yields idx 63, pend_cnt 1.
REQ-040 WIDTH=8, load_valid held high during SCAN with a second vector -> ignored until IDLE, then accepted exactly once.

Source files
------------

// File: rtl/bcp_pkg.sv
// Shared definitions for the BCP datapath blocks.
package bcp_pkg;

    // Scan encoder control state: waiting for a vector, or emitting its indices.
    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

endpackage

// File: rtl/priority_scan_encoder_if.sv
// Load/output handshake bundle for the priority scan encoder.
// master = the side that feeds vectors and consumes indices; slave = the encoder.
interface priority_scan_encoder_if #(
    parameter int WIDTH = 64
);
    localparam int IDX_W = $clog2(WIDTH);

    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_vec;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic [IDX_W:0]   pend_cnt;
    logic             flush;
    logic             done;

    modport master (
        output load_valid, load_vec, out_ready, flush,
        input  load_ready, out_valid, out_idx, out_last, pend_cnt, done
    );

    modport slave (
        input  load_valid, load_vec, out_ready, flush,
        output load_ready, out_valid, out_idx, out_last, pend_cnt, done
    );

endinterface

// File: rtl/prio_enc_param.sv
// Parametrised highest-set-bit encoder; purely combinational.
// idx is 0 when nothing is set, so 'any' is the only way to tell index 0 from empty.
module prio_enc_param #(
    parameter  int WIDTH = 64,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Ascending scan: the last set bit seen is the highest one.
    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign any = |vec;

endmodule

// File: rtl/priority_scan_encoder.sv
// Priority scan encoder: takes a request vector and emits the index of each
// set bit, highest first, one per output handshake.
module priority_scan_encoder
    import bcp_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    priority_scan_encoder_if.slave  bus
);

    localparam int IDX_W = $clog2(WIDTH);

    scan_state_t      state_reg;
    logic [WIDTH-1:0] vec_reg;
    logic [IDX_W:0]   cnt_reg;
    logic             done_reg;

    logic [IDX_W-1:0] hi_idx;
    logic             hi_any;
    logic [WIDTH-1:0] clr_mask_next;
    logic             out_fire;

    // Count of set bits, used once when a vector is accepted.
    function automatic logic [IDX_W:0] popcount(input logic [WIDTH-1:0] v);
        logic [IDX_W:0] s;
        s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            s = s + {{IDX_W{1'b0}}, v[i]};
        end
        return s;
    endfunction

    prio_enc_param #(
        .WIDTH (WIDTH)
    ) u_prio_enc (
        .vec (vec_reg),
        .idx (hi_idx),
        .any (hi_any)
    );

    assign clr_mask_next  = ~(WIDTH'(1) << hi_idx);
    assign out_fire       = (state_reg == SCAN) && bus.out_ready;

    assign bus.load_ready = (state_reg == IDLE);
    assign bus.out_valid  = (state_reg == SCAN);
    assign bus.out_idx    = ((state_reg == SCAN) && hi_any) ? hi_idx : '0;
    assign bus.out_last   = (state_reg == SCAN) && (cnt_reg == (IDX_W+1)'(1));
    assign bus.pend_cnt   = cnt_reg;
    assign bus.done       = done_reg;

    // Control FSM: flush dominates, then load in IDLE or index retirement in SCAN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            vec_reg   <= '0;
            cnt_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (bus.flush) begin
                state_reg <= IDLE;
                vec_reg   <= '0;
                cnt_reg   <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (bus.load_valid) begin
                            if (|bus.load_vec) begin
                                vec_reg   <= bus.load_vec;
                                cnt_reg   <= popcount(bus.load_vec);
                                state_reg <= SCAN;
                            end else begin
                                // Empty vector completes immediately.
                                done_reg <= 1'b1;
                            end
                        end
                    end
                    SCAN: begin
                        if (out_fire) begin
                            vec_reg <= vec_reg & clr_mask_next;
                            cnt_reg <= cnt_reg - (IDX_W+1)'(1);
                            if (cnt_reg == (IDX_W+1)'(1)) begin
                                state_reg <= IDLE;
                                done_reg  <= 1'b1;
                            end
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_priority_scan_encoder.sv
// Directed bench for priority_scan_encoder with a queue of expected indices.
module tb_priority_scan_encoder;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    priority_scan_encoder_if #(.WIDTH(8))  b8 ();
    priority_scan_encoder_if #(.WIDTH(64)) b64 ();

    priority_scan_encoder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b8)
    );

    priority_scan_encoder #(.WIDTH(64)) dut64 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b64)
    );

    // sel picks which instance is driven and observed (0 = WIDTH 8, 1 = WIDTH 64).
    int          sel;
    logic        tb_lvalid;
    logic        tb_ready;
    logic        tb_flush;
    logic [63:0] tb_lvec;

    assign b8.load_valid  = tb_lvalid && (sel == 0);
    assign b8.load_vec    = tb_lvec[7:0];
    assign b8.out_ready   = tb_ready && (sel == 0);
    assign b8.flush       = tb_flush && (sel == 0);
    assign b64.load_valid = tb_lvalid && (sel == 1);
    assign b64.load_vec   = tb_lvec;
    assign b64.out_ready  = tb_ready && (sel == 1);
    assign b64.flush      = tb_flush && (sel == 1);

    logic       m_valid, m_last, m_done, m_lready;
    logic [7:0] m_idx, m_cnt;

    assign m_valid  = (sel == 0) ? b8.out_valid  : b64.out_valid;
    assign m_last   = (sel == 0) ? b8.out_last   : b64.out_last;
    assign m_done   = (sel == 0) ? b8.done       : b64.done;
    assign m_lready = (sel == 0) ? b8.load_ready : b64.load_ready;
    assign m_idx    = (sel == 0) ? 8'(b8.out_idx)  : 8'(b64.out_idx);
    assign m_cnt    = (sel == 0) ? 8'(b8.pend_cnt) : 8'(b64.pend_cnt);

    typedef struct {
        int idx;
        int cnt;
        bit last;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Expected emission order: set bits from the top down, count decrementing.
    task automatic push_exp(input logic [63:0] v, input int w);
        int   rem;
        exp_t e;
        rem = $countones(v);
        for (int i = w - 1; i >= 0; i--) begin
            if (v[i]) begin
                e.idx  = i;
                e.cnt  = rem;
                e.last = (rem == 1);
                q.push_back(e);
                rem--;
            end
        end
    endtask

    task automatic load(input logic [63:0] v, input int w);
        chk("load_ready_before_load", 64'(m_lready), 64'd1);
        tb_lvalid = 1'b1;
        tb_lvec   = v;
        push_exp(v, w);
        tick();
        tb_lvalid = 1'b0;
        $display("load sel=%0d vec=%0h", sel, v);
        if (v == 64'd0) begin
            chk("zero_load_done", 64'(m_done), 64'd1);
            chk("zero_load_valid", 64'(m_valid), 64'd0);
            chk("zero_load_ready", 64'(m_lready), 64'd1);
        end else begin
            chk("load_latency_valid", 64'(m_valid), 64'd1);
        end
    endtask

    // Retire up to max_out queued indices; toggle applies the 1,0,0,1 ready pattern.
    task automatic drain(input int max_out, input bit toggle);
        int n;
        int c;
        n = 0;
        c = 0;
        while (q.size() > 0 && n < max_out && c < 200) begin
            tb_ready = toggle ? pat[c % 4] : 1'b1;
            chk("out_valid", 64'(m_valid), 64'd1);
            chk("out_idx", 64'(m_idx), 64'(q[0].idx));
            chk("pend_cnt", 64'(m_cnt), 64'(q[0].cnt));
            chk("out_last", 64'(m_last), 64'(q[0].last));
            chk("no_early_done", 64'(m_done), 64'd0);
            $display("out sel=%0d ready=%0b idx=%0d cnt=%0d last=%0b", sel, tb_ready, m_idx, m_cnt, m_last);
            if (tb_ready) begin
                void'(q.pop_front());
                n++;
            end
            tick();
            c++;
        end
        tb_ready = 1'b0;
        if (c >= 200) chk("drain_timeout_left", 64'(q.size()), 64'd0);
        if (q.size() == 0) begin
            chk("done_pulse", 64'(m_done), 64'd1);
            chk("idle_valid", 64'(m_valid), 64'd0);
            chk("idle_cnt", 64'(m_cnt), 64'd0);
            chk("idle_last", 64'(m_last), 64'd0);
            chk("idle_ready", 64'(m_lready), 64'd1);
        end
    endtask

    initial begin
        sel       = 0;
        tb_lvalid = 1'b0;
        tb_ready  = 1'b0;
        tb_flush  = 1'b0;
        tb_lvec   = '0;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst8_ready", 64'(b8.load_ready), 64'd1);
        chk("rst8_valid", 64'(b8.out_valid), 64'd0);
        chk("rst8_cnt", 64'(b8.pend_cnt), 64'd0);
        chk("rst64_valid", 64'(b64.out_valid), 64'd0);
        chk("rst64_done", 64'(b64.done), 64'd0);
        rst_n = 1'b1;
        tick();

        // Sparse vector, full throughput.
        load(64'hA5, 8);
        drain(99, 1'b0);
        tick();
        chk("done_one_cycle", 64'(m_done), 64'd0);

        // Empty vector.
        load(64'h00, 8);
        tick();
        chk("zero_done_clear", 64'(m_done), 64'd0);
        chk("zero_still_idle", 64'(m_valid), 64'd0);

        // All ones with stalls.
        load(64'hFF, 8);
        drain(99, 1'b1);
        tick();

        // Flush with first handshake and a same-cycle load attempt.
        load(64'h48, 8);
        chk("pre_flush_idx", 64'(m_idx), 64'd6);
        tb_ready  = 1'b1;
        tb_flush  = 1'b1;
        tb_lvalid = 1'b1;
        tb_lvec   = 64'h01;
        tick();
        tb_ready  = 1'b0;
        tb_flush  = 1'b0;
        tb_lvalid = 1'b0;
        q.delete();
        $display("flush in SCAN sel=%0d", sel);
        chk("flush_valid", 64'(m_valid), 64'd0);
        chk("flush_cnt", 64'(m_cnt), 64'd0);
        chk("flush_ready", 64'(m_lready), 64'd1);
        chk("flush_no_done", 64'(m_done), 64'd0);
        tick();
        chk("flush_no_done_late", 64'(m_done), 64'd0);
        load(64'h01, 8);
        drain(99, 1'b0);
        tick();

        // Flush in IDLE suppresses a same-cycle load.
        tb_flush  = 1'b1;
        tb_lvalid = 1'b1;
        tb_lvec   = 64'h10;
        tick();
        tb_flush  = 1'b0;
        tb_lvalid = 1'b0;
        $display("flush in IDLE sel=%0d", sel);
        chk("idle_flush_valid", 64'(m_valid), 64'd0);
        chk("idle_flush_done", 64'(m_done), 64'd0);
        chk("idle_flush_ready", 64'(m_lready), 64'd1);
        tick();

        // Second vector held during SCAN is taken exactly once afterwards.
        load(64'h81, 8);
        tb_lvalid = 1'b1;
        tb_lvec   = 64'h03;
        drain(99, 1'b0);
        push_exp(64'h03, 8);
        tick();
        tb_lvalid = 1'b0;
        chk("held_load_done_clear", 64'(m_done), 64'd0);
        drain(99, 1'b0);
        tick();
        chk("held_load_once", 64'(m_valid), 64'd0);

        // WIDTH 64: all ones, reset after 10 outputs.
        sel = 1;
        load(64'hFFFF_FFFF_FFFF_FFFF, 64);
        drain(10, 1'b0);
        chk("w64_mid_valid", 64'(m_valid), 64'd1);
        chk("w64_mid_idx", 64'(m_idx), 64'd53);
        chk("w64_mid_cnt", 64'(m_cnt), 64'd54);
        rst_n = 1'b0;
        #1;
        $display("async reset sel=%0d", sel);
        chk("arst_valid", 64'(m_valid), 64'd0);
        chk("arst_idx", 64'(m_idx), 64'd0);
        chk("arst_cnt", 64'(m_cnt), 64'd0);
        chk("arst_last", 64'(m_last), 64'd0);
        chk("arst_done", 64'(m_done), 64'd0);
        chk("arst_ready", 64'(m_lready), 64'd1);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_no_done", 64'(m_done), 64'd0);
        chk("post_rst_valid", 64'(m_valid), 64'd0);
        load(64'h8000_0000_0000_0000, 64);
        drain(99, 1'b0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
